kb_event_ctrl: RTL
==================

Name: kb_event_ctrl

Overview:
- Sequencing controller between kb_driver and the CPU's memory-mapped keyboard port.
- Turns the level-style ascii/flag output of kb_driver into discrete key events with a typematic delay and repeat.
- Queues the events in a small first-word-fall-through (FWFT) FIFO; the CPU drains it by popping.
- Replaces the ad-hoc top-level kb_state/kb_timer logic; sits beside kb_driver and feeds memory_map.

Parameters:
- DELAY_CYCLES, 25000000, cycles from the first event until the first repeat (500 ms at 50 MHz).
- REPEAT_CYCLES, 12500000, cycles between repeat events (250 ms).
- FIFO_DEPTH, 16, number of event entries; power of two, minimum 2.
- ADDR_W, 4, log2(FIFO_DEPTH).

Ports:
- clk  input  1  system clock (CLOCK_50 domain)
- rst  input  1  asynchronous active-high reset
- ascii_in  input  8  kb_driver ascii; 0 means no key held
- flags_in  input  5  {is_error, is_special, is_capital, is_ctrl, is_shift}
- pop  input  1  one-cycle CPU read strobe; consumes the head entry
- clr_ovf  input  1  clears the overflow flag
- rd_data  output  13  head entry {flags[4:0], ascii[7:0]}; 0 when empty
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  ADDR_W+1  number of queued entries
- overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset is asynchronous and active-high, on one clock.
- Reset values: FSM in IDLE, timer 0, pointers 0, count 0, empty 1, full 0, overflow 0, rd_data 0. Reset asserted mid-operation discards all queued entries and any pending repeat.
- Event contents: {flags_in, ascii_in} sampled at the push edge. last_key register holds the ascii of the most recent event.
- FSM states: IDLE, DELAY, REPEAT.
  - IDLE: if ascii_in != 0 and is_error = 0, push an event, set last_key, clear timer, go to DELAY.
  - DELAY: if ascii_in == 0 or is_error, go to IDLE with no push. Else if ascii_in != last_key, push the new key, clear timer, stay in DELAY. Else if timer == DELAY_CYCLES-1, push a repeat event, clear timer, go to REPEAT. Otherwise increment timer.
  - REPEAT: same release, error and new-key rules as DELAY (a new key returns the FSM to DELAY). When timer == REPEAT_CYCLES-1, push a repeat and clear timer.
- Latency: a key first visible in the cycle before edge k is pushed at edge k. empty falls and count increments immediately after edge k.
- Steady hold with defaults: first event at t0, then t0+DELAY_CYCLES, then every REPEAT_CYCLES after that.
- FIFO is FWFT: rd_data = mem[rd_ptr] combinationally while not empty. pop at an edge advances rd_ptr.
  - pop while empty: ignored; count stays 0.
  - push while full, no pop: event dropped, overflow set to 1, FIFO contents unchanged.
  - push and pop in the same cycle while full: both succeed, count unchanged, no overflow.
  - push and pop in the same cycle while empty: push only. The pop is ignored and the new entry appears on rd_data next cycle.
  - Pointers wrap modulo FIFO_DEPTH. full = (count == FIFO_DEPTH).
- overflow: cleared by clr_ovf. If set and clr_ovf occur in the same cycle, set wins.
- Timer width: enough bits for max(DELAY_CYCLES, REPEAT_CYCLES); must never wrap before the compare.

Optional Feature:
- Macro: KB_TYPEMATIC_EN.
- Defined: full auto-repeat behaviour as described above.
- Undefined:
  - REPEAT state and the repeat-timer logic are not synthesised.
  - DELAY holds indefinitely, emitting exactly one event per press. A change to a different nonzero key still pushes a new event.
  - DELAY_CYCLES and REPEAT_CYCLES are unused.

Test Plan:
All scenarios use DELAY_CYCLES=10, REPEAT_CYCLES=4, FIFO_DEPTH=4, ADDR_W=2, KB_TYPEMATIC_EN defined unless stated.
1. Reset then hold ascii_in=8'h61 with flags=0 for 20 cycles -> pushes at cycles 0, 10, 14, 18; rd_data=13'h0061; count=4 and full=1 at cycle 18.
2. Press 8'h61 for 3 cycles, then ascii_in=0, then pop once -> exactly one event; after the pop, empty=1, count=0, rd_data=0.
3. Hold 8'h61 past a full FIFO with no pops until the push at cycle 22 -> overflow=1, count=4, head still 8'h61. Pulse clr_ovf -> overflow=0.
4. FIFO full; at the next repeat edge assert pop -> count stays 4, overflow stays 0, head advances to the second entry.
5. Hold 8'h61 for 5 cycles, switch to 8'h62 -> second event pushed on the switch edge; next 8'h62 repeat 10 cycles later. Assert is_error mid-hold -> FSM to IDLE, no further pushes.
6. KB_TYPEMATIC_EN undefined, hold 8'h61 for 40 cycles -> exactly one event. Assert rst mid-hold with 2 entries queued -> empty=1, count=0, overflow=0 immediately (asynchronous).

Source files
------------

// File: rtl/kb_event_ctrl.sv
// kb_event_ctrl: turns kb_driver's level-style ascii/flags into discrete key
// events (first press, typematic delay, repeat) and queues them in a small
// first-word-fall-through FIFO that the CPU drains with single-cycle pops.
//
// Build option: define KB_TYPEMATIC_EN to enable auto-repeat. Without it the
// REPEAT state and the repeat timer are not built, a held key produces exactly
// one event, and DELAY_CYCLES/REPEAT_CYCLES only take part in parameter checks.

module kb_event_ctrl #(
  parameter int unsigned DELAY_CYCLES  = 25000000,
  parameter int unsigned REPEAT_CYCLES = 12500000,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned ADDR_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        ascii_in,
  input  logic [4:0]        flags_in,
  input  logic              pop,
  input  logic              clr_ovf,
  output logic [12:0]       rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam int unsigned DW = 13;

  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL  = (ADDR_W + 1)'(FIFO_DEPTH);

  // Parameter legality, caught at elaboration.
  if (FIFO_DEPTH < 2 || FIFO_DEPTH != (32'd1 << ADDR_W)) begin : g_bad_depth
    $error("kb_event_ctrl: FIFO_DEPTH must be a power of two >= 2 equal to 2**ADDR_W");
  end
  if (DELAY_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_timing
    $error("kb_event_ctrl: DELAY_CYCLES and REPEAT_CYCLES must be at least 1");
  end

`ifdef KB_TYPEMATIC_EN
  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    REPEAT
  } state_t;

  localparam int unsigned TMAX = (DELAY_CYCLES > REPEAT_CYCLES) ? DELAY_CYCLES : REPEAT_CYCLES;
  // Sized to hold TMAX itself, so the counter cannot wrap before either compare.
  localparam int unsigned TW   = $clog2(TMAX + 1);

  localparam logic [TW-1:0] DELAY_LAST  = TW'(DELAY_CYCLES - 1);
  localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);

  logic [TW-1:0] timer;
`else
  typedef enum logic {
    IDLE,
    DELAY
  } state_t;
`endif

  state_t          state;
  logic [7:0]      last_key;
  logic            key_ok;
  logic            key_new;
  logic            push;
  logic            wr_en;
  logic            rd_en;
  logic [DW-1:0]   event_word;

  logic [DW-1:0]     mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;

  // A key counts only when nonzero and not flagged as a decode error.
  assign key_ok     = (ascii_in != 8'd0) && !flags_in[4];
  assign key_new    = (ascii_in != last_key);
  assign event_word = {flags_in, ascii_in};

  // Event decision: evaluated against the current state so an event is
  // queued on the same edge that first sees the key (or timer expiry).
  always_comb begin
    push = 1'b0;
    case (state)
      IDLE: begin
        push = key_ok;
      end
      DELAY: begin
        if (key_ok && key_new) begin
          push = 1'b1;
        end
`ifdef KB_TYPEMATIC_EN
        else if (key_ok && (timer == DELAY_LAST)) begin
          push = 1'b1;
        end
`endif
      end
`ifdef KB_TYPEMATIC_EN
      REPEAT: begin
        push = key_ok && (key_new || (timer == REPEAT_LAST));
      end
`endif
      default: begin
        push = 1'b0;
      end
    endcase
  end

  // Press/hold/release sequencing; last_key tracks the key of the latest event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_key <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (key_ok) begin
            last_key <= ascii_in;
            state    <= DELAY;
          end
        end
        DELAY: begin
          if (!key_ok) begin
            state <= IDLE;
          end else if (key_new) begin
            last_key <= ascii_in;
          end
`ifdef KB_TYPEMATIC_EN
          else if (timer == DELAY_LAST) begin
            state <= REPEAT;
          end
`endif
        end
`ifdef KB_TYPEMATIC_EN
        REPEAT: begin
          if (!key_ok) begin
            state <= IDLE;
          end else if (key_new) begin
            last_key <= ascii_in;
            state    <= DELAY;
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef KB_TYPEMATIC_EN
  // Typematic timer: restarts on every event, idles at zero when no key is
  // held, otherwise counts cycles since the last event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer <= '0;
    end else if (push || !key_ok || (state == IDLE)) begin
      timer <= '0;
    end else begin
      timer <= timer + TIMER_ONE;
    end
  end
`endif

  // A push into a full FIFO only succeeds when a pop frees the head in the
  // same cycle; a pop on an empty FIFO is ignored, even alongside a push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign rd_data = empty ? '0 : mem[rd_ptr];

  // Event storage; no reset needed since the pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= event_word;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Sticky drop indicator; a new drop outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
